// File: rtl/valid_burst_if.sv
// Datavalid burst handshake bundle between a controller and the generator.
// master: generator side (takes requests, drives datavalid/status); slave: controller side.
interface valid_burst_if #(
    parameter int LEN_W = 8,
    parameter int GAP_W = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] burst_len;
    logic [GAP_W-1:0] gap_len;
    logic [CNT_W-1:0] burst_cnt;
    logic             datavalid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] burst_idx;

    modport master (
        input  start, abort, burst_len, gap_len, burst_cnt,
        output datavalid, busy, done, burst_idx
    );

    modport slave (
        output start, abort, burst_len, gap_len, burst_cnt,
        input  datavalid, busy, done, burst_idx
    );
endinterface

// File: rtl/valid_burst_gen.sv
// Programmable datavalid burst source: N bursts of L clocks high, max(G,1) low between.
// Ports: clk, rst (async active-low), bus (valid_burst_if.master: start/abort/params in, datavalid/busy/done/burst_idx out).
module valid_burst_gen #(
    parameter int LEN_W = 8,
    parameter int GAP_W = 8,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    valid_burst_if.master bus
);
    typedef enum logic [1:0] {IDLE, HIGH, GAP, FIN} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] hcnt;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gcnt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx;
    logic             dv;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] idx_nxt;
    logic             last;

    assign idx_nxt = idx + 1'b1;
    // idx never exceeds cnt_q-1, so the increment cannot wrap
    assign last    = (idx_nxt == cnt_q);

    assign bus.datavalid = dv;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.burst_idx = idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            len_q <= '0;
            hcnt  <= '0;
            gap_q <= '0;
            gcnt  <= '0;
            cnt_q <= '0;
            idx   <= '0;
            dv    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state <= IDLE;
                dv    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            len_q <= bus.burst_len;
                            // zero gap stretched to one clock
                            gap_q <= (bus.gap_len == '0) ?
                                     GAP_W'(1) : bus.gap_len;
                            cnt_q <= bus.burst_cnt;
                            idx   <= '0;
                            busy  <= 1'b1;
                            if (bus.burst_len == '0 ||
                                bus.burst_cnt == '0) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= HIGH;
                                dv    <= 1'b1;
                                hcnt  <= LEN_W'(1);
                            end
                        end
                    end
                    HIGH: begin
                        if (hcnt == len_q) begin
                            dv <= 1'b0;
                            if (last) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= GAP;
                                gcnt  <= GAP_W'(1);
                            end
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gcnt == gap_q) begin
                            state <= HIGH;
                            dv    <= 1'b1;
                            hcnt  <= LEN_W'(1);
                            idx   <= idx_nxt;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_valid_burst_gen.sv
// Scoreboard bench for valid_burst_gen: per-cycle expected outputs queued at stimulus,
// popped and compared by a negedge monitor.
module tb_valid_burst_gen;
    localparam int LEN_W = 8;
    localparam int GAP_W = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    valid_burst_if #(.LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) vif ();

    valid_burst_gen #(.LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct {
        logic             dv;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] idx;
        int               run;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   lim    = 0;
    int   pc     = 0;
    int   runid  = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (vif.datavalid === e.dv && vif.busy === e.busy &&
                vif.done === e.done && vif.burst_idx === e.idx)
                passed++;
            else
                $display("FAIL run%0d cyc%0d: got dv=%b busy=%b done=%b idx=%0d, want dv=%b busy=%b done=%b idx=%0d",
                         e.run, e.cyc, vif.datavalid, vif.busy, vif.done,
                         vif.burst_idx, e.dv, e.busy, e.done, e.idx);
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, want);
    endtask

    task automatic put(input logic dv, input logic b, input logic d,
                       input int idx);
        exp_t e;
        if (lim != 0 && pc >= lim) return;
        e.dv   = dv;
        e.busy = b;
        e.done = d;
        e.idx  = CNT_W'(idx);
        e.run  = runid;
        e.cyc  = pc;
        pc++;
        q.push_back(e);
    endtask

    // Entry 0 is the cycle in which start is presented (not yet sampled).
    task automatic gen(input int l, input int g, input int n, input int prev);
        int gm;
        gm = (g == 0) ? 1 : g;
        pc = 0;
        put(0, 0, 0, prev);
        if (l == 0 || n == 0) begin
            put(0, 1, 1, 0);
            put(0, 0, 0, 0);
        end else begin
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < l; i++) put(1, 1, 0, b);
                if (b < n - 1)
                    for (int i = 0; i < gm; i++) put(0, 1, 0, b);
            end
            put(0, 1, 1, n - 1);
            put(0, 0, 0, n - 1);
        end
    endtask

    task automatic go(input int l, input int g, input int n, input int prev);
        @(posedge clk);
        #1;
        runid++;
        vif.burst_len = LEN_W'(l);
        vif.gap_len   = GAP_W'(g);
        vif.burst_cnt = CNT_W'(n);
        vif.start     = 1'b1;
        gen(l, g, n, prev);
        @(posedge clk);
        #1;
        vif.start = 1'b0;
    endtask

    task automatic drain(input int maxc, input string nm);
        int k;
        k = 0;
        while (q.size() > 0 && k < maxc) begin
            @(posedge clk);
            k++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL %s timeout: %0d entries left, want 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        vif.start     = 1'b0;
        vif.abort     = 1'b0;
        vif.burst_len = '0;
        vif.gap_len   = '0;
        vif.burst_cnt = '0;

        #3;
        chk("rst_dv", int'(vif.datavalid), 0);
        chk("rst_busy", int'(vif.busy), 0);
        chk("rst_done", int'(vif.done), 0);
        chk("rst_idx", int'(vif.burst_idx), 0);
        #99;
        rst = 1'b1;

        @(posedge clk);
        #1;
        pc = 0;
        lim = 0;
        repeat (20) put(0, 0, 0, 0);
        drain(40, "idle");

        // single burst; inputs scrambled after start to prove latching
        lim = 0;
        go(10, 3, 1, 0);
        vif.burst_len = 8'd3;
        vif.gap_len   = 8'd7;
        vif.burst_cnt = 4'd9;
        drain(40, "single");

        lim = 0;
        go(0, 5, 4, 0);
        drain(20, "zero_len");
        lim = 0;
        go(5, 5, 0, 0);
        drain(20, "zero_cnt");

        lim = 0;
        go(1, 0, 3, 0);
        drain(20, "min");

        // abort in 4th clock of burst 2; extra start in burst 1
        lim = 25;
        go(8, 2, 5, 2);
        lim = 0;
        repeat (3) put(0, 0, 0, 2);
        for (int c = 1; c <= 24; c++) begin
            vif.start = (c == 12);
            vif.abort = (c == 24);
            @(posedge clk);
            #1;
        end
        vif.start = 1'b0;
        vif.abort = 1'b0;
        drain(20, "abort");

        lim = 0;
        go(255, 255, 15, 2);
        drain(8000, "max");

        // reset mid-run during burst 3 high (cycle 1601)
        lim = 1601;
        go(255, 255, 15, 14);
        repeat (1600) @(posedge clk);
        drain(5, "pre_rst");
        #1;
        chk("pre_rst_dv", int'(vif.datavalid), 1);
        chk("pre_rst_idx", int'(vif.burst_idx), 3);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_dv", int'(vif.datavalid), 0);
        chk("arst_busy", int'(vif.busy), 0);
        chk("arst_done", int'(vif.done), 0);
        chk("arst_idx", int'(vif.burst_idx), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        lim = 0;
        pc = 0;
        repeat (5) put(0, 0, 0, 0);
        drain(20, "post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/valid_burst_gen.md
Name: valid_burst_gen

Overview:
Programmable datavalid stimulus source. It produces bursts of datavalid pulses with exact high and low widths, and it is the producer end of the datavalid interface consumed by the clock-delay chain. It replaces hand-timed datavalid toggling in benches and on-board bring-up, and it guarantees the minimum one-clock pulse and gap widths that the delay chain requires.

Parameters:
LEN_W, 8, width of burst_len (high width per burst, in clocks)
GAP_W, 8, width of gap_len (low width between bursts, in clocks)
CNT_W, 4, width of burst_cnt and burst_idx

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-clock request; sampled only in IDLE
abort  input  1  terminate sequence; dominates start
burst_len  input  LEN_W  clocks datavalid stays high per burst
gap_len  input  GAP_W  clocks datavalid stays low between bursts
burst_cnt  input  CNT_W  number of bursts in the sequence
datavalid  output  1  generated valid, registered
busy  output  1  high from the start-accept edge until return to IDLE
done  output  1  one-clock pulse at normal sequence completion
burst_idx  output  CNT_W  index of current/last burst, 0-based

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; datavalid=0, busy=0, done=0, burst_idx=0; all internal counters and latched parameters =0.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, HIGH, GAP, FIN.
- IDLE, start=1, abort=0, burst_len!=0, burst_cnt!=0:
  - latch burst_len, gap_len and burst_cnt;
  - go to HIGH; datavalid=1 and busy=1 from that same edge, so datavalid rises one clock after start is sampled;
  - burst_idx=0.
- IDLE, start=1 with burst_len==0 or burst_cnt==0: go to FIN with busy=1. datavalid never asserts.
- HIGH: datavalid held for exactly L clocks, where L is the latched burst_len. On the L-th clock:
  - if this is the last burst, go to FIN;
  - otherwise go to GAP, with datavalid=0.
- GAP: datavalid low for exactly max(gap_len,1) clocks. gap_len=0 is treated as 1 so that consecutive bursts stay distinguishable. On exit, go to HIGH with burst_idx incremented by 1.
- FIN: done=1 for one clock, then IDLE with busy=0, done=0. burst_idx holds its last value until the next accepted start.
- Total busy duration for N bursts: N*L + (N-1)*max(G,1) + 1 clocks, where G is the latched gap_len.
- start is ignored in HIGH, GAP and FIN. Latched parameters are unaffected by input changes while busy.
- abort=1 in any non-IDLE state:
  - next edge: IDLE, datavalid=0, busy=0;
  - done is not pulsed and burst_idx holds.
  - In IDLE, abort blocks a simultaneous start.
- Counters: the high-width counter is LEN_W bits, the gap counter GAP_W bits, the burst counter CNT_W bits. They use compare-to-latched-value termination with no wrap-around, so the maximum values (255 clocks, 15 bursts) are exact.
- rst asserted mid-sequence: immediate return to reset values. No done pulse.

Test Plan:
- Reset then idle: rst low 100 ns, release, no start for 20 clocks -> datavalid, busy, done and burst_idx all 0 throughout.
- Single burst: burst_len=10, burst_cnt=1, gap_len=3, start one clock -> datavalid high exactly 10 clocks starting one clock after start; done pulses at clock 11; busy high 11 clocks.
- Minimum pulses: burst_len=1, gap_len=0, burst_cnt=3 -> datavalid pattern 1,0,1,0,1 (one clock each); burst_idx steps 0,1,2; done after the last high.
- Zero parameters: burst_len=0 with burst_cnt=4 -> no datavalid, busy high 1 clock, done pulses once; repeat with burst_cnt=0 and the same result.
- Abort and ignored start: burst_len=8, burst_cnt=5, gap_len=2; pulse start again during the second burst (ignored); assert abort at burst_idx=2 mid-high -> datavalid falls on the next clock, busy falls, done never pulses, burst_idx stays 2.
- Maximum and reset-mid-run: burst_len=255, gap_len=255, burst_cnt=15 -> each high and low measures exactly 255 clocks, 15 bursts, done once; a second run reset at burst 3 -> all outputs 0 asynchronously.
